// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a small byte FIFO feeding back-to-back 8N1 frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit (11-bit frames).
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 2604,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        trmt,
  input  logic [7:0]                  tx_data,
  output logic                        TX,
  output logic                        busy,
  output logic                        tx_done,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        tx_ovr
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int BCW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  typedef enum logic {S_IDLE, S_TX} state_t;

  logic [7:0]            mem_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  tx_ovr_q;
  state_t                state_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] load_d;
  logic [BCW-1:0]        baud_q;
  logic [3:0]            bit_q;
  logic                  busy_q;
  logic                  tx_done_q;
  logic                  push;
  logic                  pop;
  logic                  shift;
  logic                  frame_end;
  logic [7:0]            head;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push      = trmt && !full;
  assign shift     = (state_q == S_TX) && (baud_q == BCW'(CLKS_PER_BIT - 1));
  assign frame_end = shift && (bit_q == 4'(FRAME_BITS - 1));
  assign pop       = !empty && ((state_q == S_IDLE) || frame_end);
  assign count_d   = count_q + CW'(push) - CW'(pop);
  assign head      = mem_q[rd_ptr_q];

`ifdef UART_TX_PARITY_EN
  assign load_d = {1'b1, ^head, head, 1'b0};
`else
  assign load_d = {1'b1, head, 1'b0};
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // Full is judged before any same-cycle pop, so a push at full is always rejected.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_ovr_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= count_d;
      tx_ovr_q <= trmt && full;
    end
  end

  // The end-of-stop-bit edge both closes the frame and may reload the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
      shift_q   <= '1;
      baud_q    <= '0;
      bit_q     <= '0;
    end else begin
      tx_done_q <= frame_end;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            shift_q <= load_d;
            baud_q  <= '0;
            bit_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_TX;
          end
        end
        S_TX: begin
          if (frame_end) begin
            baud_q <= '0;
            bit_q  <= '0;
            if (pop) begin
              shift_q <= load_d;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else if (shift) begin
            shift_q <= {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_q   <= bit_q + 4'd1;
            baud_q  <= '0;
          end else begin
            baud_q <= baud_q + BCW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign TX      = shift_q[0];
  assign busy    = busy_q;
  assign tx_done = tx_done_q;
  assign count   = count_q;
  assign tx_ovr  = tx_ovr_q;

endmodule
